// File: rtl/axi_lite_shared_mem_arbiter.sv
// 2:1 AXI4-Lite arbiter sharing one block-memory slave between two upstream masters.
// One transaction in flight, round-robin over {s0W, s0R, s1W, s1R}, DECERR for out-of-window addresses.
module axi_lite_shared_mem_arbiter #(
  parameter int                  ADDR_WIDTH     = 32,
  parameter int                  DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE    = {ADDR_WIDTH{1'b0}},
  parameter int                  ADDR_SPAN_LOG2 = 13
) (
  input  logic                      s_aclk,
  input  logic                      s_aresetn,
  // upstream port 0
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  // upstream port 1
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,
  // downstream port to block memory
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_FWD     = 4'd1,
    ST_WR_RSP     = 4'd2,
    ST_RD_FWD     = 4'd3,
    ST_RD_RSP     = 4'd4,
    ST_WR_ERR     = 4'd5,
    ST_WR_ERR_RSP = 4'd6,
    ST_RD_ERR     = 4'd7,
    ST_RD_ERR_RSP = 4'd8
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_rr;
  logic                    r_gnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [SW-1:0]           r_wstrb;
  logic                    r_aw_done;
  logic                    r_w_done;

  logic [3:0]              w_cand;
  logic [2:0]              w_pick_res;
  logic                    w_pick_valid;
  logic [1:0]              w_pick;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [SW-1:0]           w_sel_wstrb;
  logic                    w_in_range;
  logic                    w_g_bready;
  logic                    w_g_rready;

  logic                    w_up_awready;
  logic                    w_up_wready;
  logic                    w_up_arready;
  logic                    w_up_bvalid;
  logic [1:0]              w_up_bresp;
  logic                    w_up_rvalid;
  logic [1:0]              w_up_rresp;
  logic [DATA_WIDTH-1:0]   w_up_rdata;

  // First asserted candidate at or after the pointer; result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    logic [1:0] sel;
    found = 1'b0;
    sel   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  assign w_cand       = {s1_arvalid, s1_awvalid & s1_wvalid, s0_arvalid, s0_awvalid & s0_wvalid};
  assign w_pick_res   = rr_pick(w_cand, r_rr);
  assign w_pick_valid = w_pick_res[2];
  assign w_pick       = w_pick_res[1:0];

  // w_pick[1] selects the master, w_pick[0] selects read (1) or write (0)
  assign w_sel_addr  = w_pick[1] ? (w_pick[0] ? s1_araddr : s1_awaddr)
                                 : (w_pick[0] ? s0_araddr : s0_awaddr);
  assign w_sel_wdata = w_pick[1] ? s1_wdata : s0_wdata;
  assign w_sel_wstrb = w_pick[1] ? s1_wstrb : s0_wstrb;
  assign w_in_range  = (w_sel_addr[ADDR_WIDTH-1:ADDR_SPAN_LOG2] == ADDR_BASE[ADDR_WIDTH-1:ADDR_SPAN_LOG2]);
  assign w_g_bready  = r_gnt ? s1_bready : s0_bready;
  assign w_g_rready  = r_gnt ? s1_rready : s0_rready;

  // State, grant pointer and captured request payload.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_state   <= ST_IDLE;
      r_rr      <= 2'd0;
      r_gnt     <= 1'b0;
      r_addr    <= {ADDR_WIDTH{1'b0}};
      r_wdata   <= {DATA_WIDTH{1'b0}};
      r_wstrb   <= {SW{1'b0}};
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_IDLE) && w_pick_valid) begin
        r_gnt     <= w_pick[1];
        r_rr      <= w_pick + 2'd1;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_wstrb   <= w_sel_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (r_state == ST_WR_FWD) begin
        r_aw_done <= r_aw_done | (m_awvalid & m_awready);
        r_w_done  <= r_w_done | (m_wvalid & m_wready);
      end else begin
        r_aw_done <= r_aw_done;
        r_w_done  <= r_w_done;
      end
    end
  end

  assign m_awaddr = r_addr;
  assign m_araddr = r_addr;
  assign m_wdata  = r_wdata;
  assign m_wstrb  = r_wstrb;

  // Next state plus per-state channel steering towards a grant-neutral upstream view.
  always_comb begin
    w_next_state = r_state;
    m_awvalid    = 1'b0;
    m_wvalid     = 1'b0;
    m_arvalid    = 1'b0;
    m_bready     = 1'b0;
    m_rready     = 1'b0;
    w_up_awready = 1'b0;
    w_up_wready  = 1'b0;
    w_up_arready = 1'b0;
    w_up_bvalid  = 1'b0;
    w_up_bresp   = 2'b00;
    w_up_rvalid  = 1'b0;
    w_up_rresp   = 2'b00;
    w_up_rdata   = {DATA_WIDTH{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          if (w_pick[0]) begin
            w_next_state = w_in_range ? ST_RD_FWD : ST_RD_ERR;
          end else begin
            w_next_state = w_in_range ? ST_WR_FWD : ST_WR_ERR;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WR_FWD: begin
        m_awvalid    = ~r_aw_done;
        m_wvalid     = ~r_w_done;
        w_up_awready = m_awready & ~r_aw_done;
        w_up_wready  = m_wready & ~r_w_done;
        if ((r_aw_done | m_awready) & (r_w_done | m_wready)) begin
          w_next_state = ST_WR_RSP;
        end else begin
          w_next_state = ST_WR_FWD;
        end
      end
      ST_WR_RSP: begin
        m_bready    = w_g_bready;
        w_up_bvalid = m_bvalid;
        w_up_bresp  = m_bresp;
        if (m_bvalid & w_g_bready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WR_RSP;
        end
      end
      ST_RD_FWD: begin
        m_arvalid    = 1'b1;
        w_up_arready = m_arready;
        if (m_arready) begin
          w_next_state = ST_RD_RSP;
        end else begin
          w_next_state = ST_RD_FWD;
        end
      end
      ST_RD_RSP: begin
        m_rready    = w_g_rready;
        w_up_rvalid = m_rvalid;
        w_up_rresp  = m_rresp;
        w_up_rdata  = m_rdata;
        if (m_rvalid & w_g_rready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RD_RSP;
        end
      end
      ST_WR_ERR: begin
        w_up_awready = 1'b1;
        w_up_wready  = 1'b1;
        w_next_state = ST_WR_ERR_RSP;
      end
      ST_WR_ERR_RSP: begin
        w_up_bvalid = 1'b1;
        w_up_bresp  = 2'b11;
        if (w_g_bready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WR_ERR_RSP;
        end
      end
      ST_RD_ERR: begin
        w_up_arready = 1'b1;
        w_next_state = ST_RD_ERR_RSP;
      end
      ST_RD_ERR_RSP: begin
        w_up_rvalid = 1'b1;
        w_up_rresp  = 2'b11;
        if (w_g_rready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RD_ERR_RSP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // The non-granted master sees every ready/valid low and zero payload.
  assign s0_awready = ~r_gnt & w_up_awready;
  assign s0_wready  = ~r_gnt & w_up_wready;
  assign s0_arready = ~r_gnt & w_up_arready;
  assign s0_bvalid  = ~r_gnt & w_up_bvalid;
  assign s0_bresp   = r_gnt ? 2'b00 : w_up_bresp;
  assign s0_rvalid  = ~r_gnt & w_up_rvalid;
  assign s0_rresp   = r_gnt ? 2'b00 : w_up_rresp;
  assign s0_rdata   = r_gnt ? {DATA_WIDTH{1'b0}} : w_up_rdata;

  assign s1_awready = r_gnt & w_up_awready;
  assign s1_wready  = r_gnt & w_up_wready;
  assign s1_arready = r_gnt & w_up_arready;
  assign s1_bvalid  = r_gnt & w_up_bvalid;
  assign s1_bresp   = r_gnt ? w_up_bresp : 2'b00;
  assign s1_rvalid  = r_gnt & w_up_rvalid;
  assign s1_rresp   = r_gnt ? w_up_rresp : 2'b00;
  assign s1_rdata   = r_gnt ? w_up_rdata : {DATA_WIDTH{1'b0}};

endmodule
